data_mem_ctrl: RTL and testbench

//  Parametrised data memory for the MIPS datapath, replacing the single-cycle word RAM.

---
 rtl/data_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory with req/ready handshake, RD_LAT-deep load pipeline and zero-fill sweep.
// Optional feature: define MEM_MISALIGN_TRAP_EN to fault misaligned h/hu/w accesses instead of aligning them.
module data_mem_ctrl #(
  parameter int ADDR_BITS = 12,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 clr,
  input  logic                 req,
  input  logic                 we,
  input  logic [2:0]           mode,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic                 ready,
  output logic                 rvalid,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic                 busy
);

  localparam int IW    = ADDR_BITS - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic {SWEEP, RUN} state_t;

  typedef struct packed {
    logic        ld;
    logic        bad;
    logic [2:0]  mode;
    logic [1:0]  lane;
    logic [31:0] word;
  } rsp_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       cnt, cnt_nxt;
  logic [31:0]         mem [DEPTH];
  logic                acc, legal, mis, bad, is_h, is_w;
  logic [IW-1:0]       idx;
  logic [1:0]          lane;
  logic [3:0]          be;
  logic [31:0]         wword;
  logic [RD_LAT-1:0]   vld_pipe;
  rsp_t [RD_LAT-1:0]   pipe;
  rsp_t                tail;

  // ---------------- sweep / run control ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= SWEEP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      SWEEP: begin
        busy    = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == IW'(DEPTH - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        ready = !clr;
        if (clr) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = SWEEP;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign acc = req && ready;
  assign idx = addr[ADDR_BITS-1:2];

  // ---------------- access decode ----------------
  always_comb begin
    legal = (mode == 3'b000) || (mode == 3'b001) || (mode == 3'b010) ||
            (mode == 3'b100) || (mode == 3'b101);
    is_h  = (mode[1:0] == 2'b01);
    is_w  = (mode[1:0] == 2'b10);
`ifdef MEM_MISALIGN_TRAP_EN
    mis   = legal && ((is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00)));
    lane  = addr[1:0];
`else
    // Misaligned low bits are dropped so the access lands on its natural boundary.
    mis   = 1'b0;
    lane  = is_w ? 2'b00 : (is_h ? {addr[1], 1'b0} : addr[1:0]);
`endif
    bad   = !legal || mis;
    case (mode[1:0])
      2'b00:   begin be = 4'b0001 << lane;                  wword = {4{wdata[7:0]}};  end
      2'b01:   begin be = lane[1] ? 4'b1100 : 4'b0011;      wword = {2{wdata[15:0]}}; end
      default: begin be = 4'b1111;                          wword = wdata;            end
    endcase
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (acc && we && !bad) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  // ---------------- response pipeline ----------------
  // Stage 0 captures the word at the accept edge; a store written on the previous
  // edge is already visible here, which gives read-after-write for free.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vld_pipe <= '0;
      pipe     <= '0;
    end else begin
      vld_pipe[0]   <= acc && (!we || bad);
      pipe[0].ld    <= !we;
      pipe[0].bad   <= bad;
      pipe[0].mode  <= mode;
      pipe[0].lane  <= lane;
      pipe[0].word  <= mem[idx];
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pipe[i]     <= pipe[i-1];
      end
    end
  end

  function automatic logic [31:0] extend(input rsp_t r);
    logic [7:0]  b;
    logic [15:0] h;
    b = r.word[8*r.lane +: 8];
    h = r.word[16*r.lane[1] +: 16];
    case (r.mode[1:0])
      2'b00:   extend = r.mode[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extend = r.mode[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: extend = r.word;
    endcase
  endfunction

  assign tail   = pipe[RD_LAT-1];
  assign rvalid = vld_pipe[RD_LAT-1] && tail.ld;
  assign err    = vld_pipe[RD_LAT-1] && tail.bad;
  assign rdata  = (rvalid && !tail.bad) ? extend(tail) : 32'h0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: RD_LAT=1 and RD_LAT=3 instances share one stimulus stream.
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0, clr_n = 1'b0, clr = 1'b0, req = 1'b0, we = 1'b0;
  logic [2:0]  mode = 3'b0;
  logic [11:0] addr = 12'h0;
  logic [31:0] wdata = 32'h0;
  logic        rdy1, rv1, er1, bs1, rdy3, rv3, er3, bs3;
  logic [31:0] rd1, rd3;

  data_mem_ctrl #(.ADDR_BITS(12), .RD_LAT(1)) u1 (
    .clk(clk), .clr_n(clr_n), .clr(clr), .req(req), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .ready(rdy1), .rvalid(rv1), .rdata(rd1), .err(er1), .busy(bs1));

  data_mem_ctrl #(.ADDR_BITS(12), .RD_LAT(3)) u3 (
    .clk(clk), .clr_n(clr_n), .clr(clr), .req(req), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .ready(rdy3), .rvalid(rv3), .rdata(rd3), .err(er3), .busy(bs3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        er;
    logic        ld;
    int          due;
  } exp_t;

  exp_t q1[$], q3[$];

  task automatic mon(input int k, input logic rv, input logic er, input logic [31:0] rd);
    exp_t e;
    int   n;
    n = (k != 0) ? q3.size() : q1.size();
    while (n > 0) begin
      e = (k != 0) ? q3[0] : q1[0];
      if (e.due >= cyc) break;
      chk($sformatf("lost_lat%0d", k ? 3 : 1), 0, 1);
      if (k != 0) e = q3.pop_front(); else e = q1.pop_front();
      n--;
    end
    if (rv || er) begin
      if (n == 0) begin
        chk($sformatf("unexpected_lat%0d", k ? 3 : 1), {30'h0, rv, er}, 0);
      end else begin
        if (k != 0) e = q3.pop_front(); else e = q1.pop_front();
        chk($sformatf("due_lat%0d", k ? 3 : 1), cyc, e.due);
        chk($sformatf("rdata_lat%0d", k ? 3 : 1), rd, e.data);
        chk($sformatf("err_lat%0d", k ? 3 : 1), er, e.er);
        chk($sformatf("rvalid_lat%0d", k ? 3 : 1), rv, e.ld);
      end
    end else begin
      chk($sformatf("rdata_idle_lat%0d", k ? 3 : 1), rd, 0);
    end
  endtask

  always @(negedge clk) begin
    if (clr_n) begin
      mon(0, rv1, er1, rd1);
      mon(1, rv3, er3, rd3);
    end
  end

  // Drives one request for the coming edge; sb=1 queues the expected response.
  task automatic issue(input logic w, input logic [2:0] m, input logic [11:0] a,
                       input logic [31:0] d, input logic [31:0] exp, input logic e_err,
                       input logic sb);
    exp_t e;
    @(posedge clk); #1;
    req = 1'b1; we = w; mode = m; addr = a; wdata = d;
    #1;
    chk("ready_at_issue", rdy1, 1);
    if (sb) begin
      e.data = exp; e.er = e_err; e.ld = !w;
      e.due = cyc + 1; q1.push_back(e);
      e.due = cyc + 3; q3.push_back(e);
    end
  endtask

  task automatic st(input logic [2:0] m, input logic [11:0] a, input logic [31:0] d);
    issue(1'b1, m, a, d, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic ld(input logic [2:0] m, input logic [11:0] a, input logic [31:0] exp);
    issue(1'b0, m, a, 32'h0, exp, 1'b0, 1'b1);
  endtask
  task automatic bad_ld(input logic [2:0] m, input logic [11:0] a);
    issue(1'b0, m, a, 32'h0, 32'h0, 1'b1, 1'b1);
  endtask
  task automatic bad_st(input logic [2:0] m, input logic [11:0] a, input logic [31:0] d);
    issue(1'b1, m, a, d, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req = 1'b0; clr = 1'b0; we = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() + q3.size()) != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q1.size() + q3.size(), 0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy1 || n > 3000) break;
      n++;
    end
  endtask

  int n;

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy1, 0);
    chk("rst_rvalid", {rv1, rv3}, 0);
    chk("rst_rdata", rd1 | rd3, 0);
    chk("rst_err", {er1, er3}, 0);
    chk("rst_busy", {bs1, bs3}, 2'b11);

    @(posedge clk); #1 clr_n = 1'b1;
    wait_ready(n);
    chk("sweep_len", n, DEPTH);
    chk("busy_run", {bs1, bs3}, 0);
    chk("ready_lat3", rdy3, 1);

    ld(3'b010, 12'h040, 32'h0);
    ld(3'b010, 12'hFFC, 32'h0);

    // sign/zero extension
    st(3'b010, 12'h010, 32'h8000_00F0);
    ld(3'b000, 12'h010, 32'hFFFF_FFF0);
    ld(3'b100, 12'h010, 32'h0000_00F0);
    ld(3'b001, 12'h012, 32'hFFFF_8000);
    ld(3'b101, 12'h012, 32'h0000_8000);

    // byte merge and read-after-write
    st(3'b010, 12'h020, 32'h1122_3344);
    st(3'b000, 12'h021, 32'h0000_00AA);
    ld(3'b010, 12'h020, 32'h1122_AA44);

    // back-to-back loads
    st(3'b010, 12'h000, 32'hA1A2_A3A4);
    st(3'b010, 12'h004, 32'hB1B2_B3B4);
    st(3'b010, 12'h008, 32'hC1C2_C3C4);
    ld(3'b010, 12'h000, 32'hA1A2_A3A4);
    ld(3'b010, 12'h004, 32'hB1B2_B3B4);
    ld(3'b010, 12'h008, 32'hC1C2_C3C4);

    // illegal modes: no write, err pulse
    bad_ld(3'b011, 12'h020);
    bad_st(3'b111, 12'h020, 32'hFFFF_FFFF);
    ld(3'b010, 12'h020, 32'h1122_AA44);

    // misalignment
`ifdef MEM_MISALIGN_TRAP_EN
    bad_ld(3'b010, 12'h022);
    bad_ld(3'b001, 12'h023);
`else
    ld(3'b010, 12'h022, 32'h1122_AA44);
    ld(3'b001, 12'h023, 32'h0000_1122);
`endif
    idle();
    drain();

    // clr with a load in flight and a competing request
    ld(3'b010, 12'h020, 32'h1122_AA44);
    @(posedge clk); #1;
    clr = 1'b1; req = 1'b1; we = 1'b0; mode = 3'b010; addr = 12'h020;
    #1 chk("ready_under_clr", rdy1, 0);
    @(posedge clk); #1;
    clr = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("busy_after_clr", {bs1, bs3}, 2'b11);
    wait_ready(n);
    chk("clr_sweep_len", n, DEPTH - 1);
    ld(3'b010, 12'h020, 32'h0);
    ld(3'b010, 12'h010, 32'h0);
    idle();
    drain();

    // reset in the middle of a load
    st(3'b010, 12'h030, 32'h5A5A_5A5A);
    issue(1'b0, 3'b010, 12'h030, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    clr_n = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", {rv1, rv3}, 0);
    chk("rst_mid_busy", {bs1, bs3}, 2'b11);
    chk("rst_mid_ready", rdy1, 0);
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    wait_ready(n);
    chk("rst_sweep_len", n, DEPTH);
    ld(3'b010, 12'h030, 32'h0);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
